// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder
// Word-addressed backing store with an ibex-style req/gnt/rvalid data
// interface. Accepted requests are answered in order through a small
// response FIFO whose depth bounds the number of outstanding requests.
// Grant and response hooks (stall_gnt_i / stall_rsp_i) let a bench apply
// back-pressure and extra latency.

module ibex_mem_responder #(
  parameter int unsigned            ADDR_WIDTH      = 32,
  parameter int unsigned            DATA_WIDTH      = 32,
  parameter int unsigned            DEPTH_WORDS     = 64,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
  parameter int unsigned            MAX_OUTSTANDING = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  req_i,
  output logic                                  gnt_o,
  input  logic [ADDR_WIDTH-1:0]                 addr_i,
  input  logic                                  we_i,
  input  logic [DATA_WIDTH/8-1:0]               be_i,
  input  logic [DATA_WIDTH-1:0]                 wdata_i,
  output logic                                  rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rdata_o,
  output logic                                  err_o,
  input  logic                                  stall_gnt_i,
  input  logic                                  stall_rsp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AW1   = ADDR_WIDTH + 1;

  // Range limits carry one extra bit so BASE_ADDR + span cannot wrap.
  localparam logic [AW1-1:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [AW1-1:0] HI_ADDR = LO_ADDR + AW1'(4 * DEPTH_WORDS);

  // Advance a FIFO pointer, wrapping at the (not necessarily power-of-2) depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Backing store and response FIFO state.
  logic [DATA_WIDTH-1:0] r_mem       [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_fifo_data [MAX_OUTSTANDING];
  logic                  r_fifo_err  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;

  logic [AW1-1:0]        w_addr_ext;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_rvalid;
  logic                  w_gnt;
  logic                  w_accept;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_push_err;
  logic                  w_unused;

  // Address decode: byte offsets [1:0] are dropped when forming the word index.
  assign w_addr_ext = {1'b0, addr_i};
  assign w_in_range = (w_addr_ext >= LO_ADDR) && (w_addr_ext < HI_ADDR);
  assign w_offset   = addr_i - BASE_ADDR;
  assign w_idx      = w_offset[IDX_W+1:2];
  assign w_unused   = ^w_offset;

  // A response leaves whenever the FIFO holds one and the latency hook allows.
  assign w_rvalid = rst_ni && (r_occ != '0) && !stall_rsp_i;
  // A full FIFO may still grant when its head is popping this same cycle.
  assign w_gnt    = rst_ni && req_i && !stall_gnt_i &&
                    ((r_occ < OCC_W'(MAX_OUTSTANDING)) || w_rvalid);
  assign w_accept = req_i && w_gnt;
  assign w_pop    = w_rvalid;

  assign gnt_o         = w_gnt;
  assign rvalid_o      = w_rvalid;
  assign outstanding_o = r_occ;

  // Build the response for the request being accepted (read data sampled now).
  always_comb begin
    w_push_data = '0;
    w_push_err  = 1'b0;
    if (!w_in_range) begin
      w_push_err = 1'b1;
    end else if (!we_i) begin
      w_push_data = r_mem[w_idx];
    end else begin
      w_push_data = '0;
    end
  end

  // Present the FIFO head only while a response is valid; otherwise zeros.
  always_comb begin
    rdata_o = '0;
    err_o   = 1'b0;
    if (w_rvalid) begin
      rdata_o = r_fifo_data[r_rd_ptr];
      err_o   = r_fifo_err[r_rd_ptr];
    end else begin
      rdata_o = '0;
      err_o   = 1'b0;
    end
  end

  // Backing store: cleared on reset, byte-masked update on accepted writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept && w_in_range && we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) begin
          r_mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Response FIFO payload: written at the accept edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else if (w_accept) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_err[r_wr_ptr]  <= w_push_err;
    end
  end

  // Response FIFO pointers and occupancy; reset discards pending responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder (default parameters): directed scenarios plus
// a randomised phase; a reference memory model feeds an in-order scoreboard.

module tb_ibex_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        stall_gnt_i;
  logic        stall_rsp_i;
  logic [1:0]  outstanding_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] exp_q[$];       // {rdata, err}
  logic [31:0] m_mem [64];

  ibex_mem_responder dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .stall_gnt_i   (stall_gnt_i),
    .stall_rsp_i   (stall_rsp_i),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk_i) begin
    logic [32:0] e;
    logic        exp_gnt;
    if (!rst_ni) begin
      exp_q.delete();
      for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
    end else begin
      check_eq("occupancy", 64'(outstanding_o), 64'(exp_q.size()));
      exp_gnt = req_i && !stall_gnt_i && ((exp_q.size() < 2) || rvalid_o);
      check_eq("gnt", 64'(gnt_o), 64'(exp_gnt));
      if (rvalid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", 64'(rvalid_o), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp", 64'({rdata_o, err_o}), 64'(e));
        end
      end else begin
        check_eq("idle_zero", 64'({rdata_o, err_o}), 64'(0));
      end
      if (req_i && gnt_o) begin
        if (addr_i >= 32'h100) begin
          exp_q.push_back({32'h0, 1'b1});
        end else if (we_i) begin
          for (int b = 0; b < 4; b++)
            if (be_i[b]) m_mem[addr_i[7:2]][b*8 +: 8] = wdata_i[b*8 +: 8];
          exp_q.push_back({32'h0, 1'b0});
        end else begin
          exp_q.push_back({m_mem[addr_i[7:2]], 1'b0});
        end
      end
    end
  end

  // Issue one request starting just after a rising edge; returns cycles waited.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int waited);
    int n = 0;
    req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
    @(negedge clk_i);
    while (!gnt_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!gnt_o) check_eq("grant_timeout", 64'(gnt_o), 64'(1));
    waited = n;
    @(posedge clk_i); #1;
    req_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (outstanding_o != 2'd0 && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_eq("drain", 64'(outstanding_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  done;
    logic [31:0] a;
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; be_i = 4'h0;
    wdata_i = 32'h0; stall_gnt_i = 1'b0; stall_rsp_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_gnt",    64'(gnt_o),         64'(0));
    check_eq("rst_rvalid", 64'(rvalid_o),      64'(0));
    check_eq("rst_rdata",  64'(rdata_o),       64'(0));
    check_eq("rst_err",    64'(err_o),         64'(0));
    check_eq("rst_occ",    64'(outstanding_o), 64'(0));
    req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Write then read back, single-cycle grant and one-cycle response latency.
    do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w);
    check_eq("wr_gnt_lat", 64'(w), 64'(0));
    check_eq("wr_rvalid_next", 64'(rvalid_o), 64'(1));
    do_req(1'b0, 32'h10, 4'h0, 32'h0, w);
    check_eq("rd_gnt_lat", 64'(w), 64'(0));
    check_eq("rd_rvalid_next", 64'(rvalid_o), 64'(1));
    check_eq("rd_deadbeef", 64'(rdata_o), 64'(32'hDEADBEEF));

    // Byte-masked write, then a be=0 write that must change nothing.
    do_req(1'b1, 32'h10, 4'h1, 32'h000000AA, w);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, w);
    check_eq("rd_deadbeaa", 64'(rdata_o), 64'(32'hDEADBEAA));
    do_req(1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, w);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, w);

    // Out of range: error response, no aliasing into word 0; low bits ignored.
    do_req(1'b0, 32'h100, 4'h0, 32'h0, w);
    check_eq("oor_err", 64'({rdata_o, err_o}), 64'({32'h0, 1'b1}));
    do_req(1'b1, 32'h100, 4'hF, 32'h12345678, w);
    do_req(1'b0, 32'h0, 4'h0, 32'h0, w);
    do_req(1'b1, 32'h13, 4'hF, 32'h000055AA, w);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, w);
    drain();

    // Response stall: two grants fill the FIFO, third waits for the release.
    stall_rsp_i = 1'b1;
    do_req(1'b0, 32'h10, 4'h0, 32'h0, w);
    do_req(1'b0, 32'h14, 4'h0, 32'h0, w);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h18;
    repeat (3) begin
      @(negedge clk_i);
      check_eq("full_nogrant", 64'(gnt_o), 64'(0));
      check_eq("full_occ", 64'(outstanding_o), 64'(2));
    end
    @(posedge clk_i); #1;
    stall_rsp_i = 1'b0;
    @(negedge clk_i);
    check_eq("full_pop_grant", 64'(gnt_o), 64'(1));
    @(posedge clk_i); #1;
    req_i = 1'b0;
    drain();

    // Grant stall: no grant for five cycles, grant once released.
    stall_gnt_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
    repeat (5) begin
      @(negedge clk_i);
      check_eq("stall_gnt", 64'(gnt_o), 64'(0));
      check_eq("stall_gnt_rv", 64'(rvalid_o), 64'(0));
    end
    @(posedge clk_i); #1;
    stall_gnt_i = 1'b0;
    @(negedge clk_i);
    check_eq("stall_gnt_release", 64'(gnt_o), 64'(1));
    @(posedge clk_i); #1;
    req_i = 1'b0;
    drain();

    // Random traffic with random back-pressure on both hooks.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          a = 32'($urandom_range(0, 80) * 4 + $urandom_range(0, 3));
          do_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, w);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_i); #1;
          stall_rsp_i = ($urandom_range(0, 2) == 0);
          stall_gnt_i = ($urandom_range(0, 3) == 0);
        end
        stall_rsp_i = 1'b0;
        stall_gnt_i = 1'b0;
      end
    join
    drain();

    // Reset with two responses pending: discarded, memory cleared.
    stall_rsp_i = 1'b1;
    do_req(1'b0, 32'h10, 4'h0, 32'h0, w);
    do_req(1'b0, 32'h14, 4'h0, 32'h0, w);
    check_eq("pre_rst_occ", 64'(outstanding_o), 64'(2));
    rst_ni = 1'b0; req_i = 1'b1;
    #1;
    check_eq("mid_rst_occ",    64'(outstanding_o), 64'(0));
    check_eq("mid_rst_rvalid", 64'(rvalid_o),      64'(0));
    check_eq("mid_rst_gnt",    64'(gnt_o),         64'(0));
    req_i = 1'b0;
    @(posedge clk_i); #1;
    stall_rsp_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    check_eq("post_rst_rvalid", 64'(rvalid_o), 64'(0));
    do_req(1'b0, 32'h10, 4'h0, 32'h0, w);
    check_eq("post_rst_rdata", 64'({rdata_o, err_o}), 64'(0));
    drain();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ibex_mem_responder.md
IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter DEPTH_WORDS, default 64, backing-store size in words (power of 2).
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0 (word-aligned).
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered requests (>=1).
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk_i (input, 1, clock) and rst_ni (input, 1, async reset, active low).
REQ-007 SHALL have req_i  input  1  request valid from initiator.
REQ-008 SHALL have gnt_o  output  1  request accepted this cycle.
REQ-009 SHALL have addr_i  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have we_i  input  1  1=write, 0=read.
REQ-011 SHALL have be_i  input  DATA_WIDTH/8  byte enables.
REQ-012 SHALL have wdata_i  input  DATA_WIDTH  write data.
REQ-013 SHALL have rvalid_o  output  1  response valid.
REQ-014 SHALL have rdata_o  output  DATA_WIDTH  read data.
REQ-015 SHALL have err_o  output  1  response error; qualified by rvalid_o.
REQ-016 SHALL have stall_gnt_i  input  1  suppress grant (back-pressure hook).
REQ-017 SHALL have stall_rsp_i  input  1  hold responses (latency hook).
REQ-018 SHALL have outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current response-queue occupancy.

Function
REQ-019 SHALL drive gnt_o = req_i & ~stall_gnt_i & (occupancy < MAX_OUTSTANDING | rvalid_o); accept = req_i & gnt_o.
REQ-020 SHALL treat an address as in-range iff BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH_WORDS; word index = (addr_i - BASE_ADDR) >> 2; addr_i[1:0] ignored.
REQ-021 SHALL, on an accepted in-range write, update at that clock edge only the bytes with be_i set, then push response {rdata=0, err=0}.
REQ-022 SHALL, on an accepted in-range read, capture the word at that edge (reflecting all earlier writes) and push {rdata=word, err=0}.
REQ-023 SHALL, on any accepted out-of-range request, leave storage unchanged and push {rdata=0, err=1}.
REQ-024 SHALL hold responses in an in-order FIFO of depth MAX_OUTSTANDING; responses SHALL return in acceptance order.
REQ-025 SHALL drive rvalid_o = (occupancy != 0) & ~stall_rsp_i, with rdata_o/err_o from the FIFO head, and 0 when rvalid_o=0.
REQ-026 SHALL pop the head at each edge where rvalid_o=1; earliest rvalid_o is the cycle after the grant (latency 1).
REQ-027 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve order; full FIFO with pop SHALL still grant.
REQ-028 SHALL never grant when occupancy == MAX_OUTSTANDING and rvalid_o=0 (full, no pop).
REQ-029 SHALL handle be_i = 0 writes as accepted, no byte changed, err=0 response.
REQ-030 SHALL not require req_i to stay asserted if ungranted; attributes are sampled only in the accept cycle.
REQ-031 SHALL wrap FIFO pointers modulo MAX_OUTSTANDING without losing or duplicating entries.

Reset
REQ-032 SHALL, while rst_ni=0, force gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0 and clear all storage words to 0.
REQ-033 SHALL, on reset mid-operation, discard all pending responses; no rvalid_o for them after reset release.
REQ-034 SHALL accept requests from the first clock edge with rst_ni=1.

Verification
REQ-035 SHALL cover: write 0xDEADBEEF to 0x10 be=0xF, then read 0x10 -> gnt same cycle as req, rvalid next cycle each, read rdata=0xDEADBEEF, err=0.
REQ-036 SHALL cover: after REQ-035, write 0x000000AA to 0x10 be=0x1, read 0x10 -> rdata=0xDEADBEAA.
REQ-037 SHALL cover: read 0x100 (DEPTH_WORDS=64, BASE_ADDR=0) -> rvalid with err=1, rdata=0; write to 0x100 leaves storage unchanged.
REQ-038 SHALL cover: stall_rsp_i=1, three back-to-back read requests -> two granted, third held until stall_rsp_i=0; outstanding_o reaches 2; three in-order responses.
REQ-039 SHALL cover: stall_gnt_i=1 with req_i=1 for 5 cycles -> gnt_o=0 throughout, no response; release -> grant next cycle.
REQ-040 SHALL cover: assert rst_ni=0 with 2 responses pending -> outstanding_o=0, rvalid_o=0 immediately; read of 0x10 after release -> rdata=0.
